// File: rtl/ro_puf_pkg.sv
// Shared types and sizes for the ring-oscillator PUF challenge sequencer.
package ro_puf_pkg;

    localparam int unsigned NUM_RO   = 16;
    localparam int unsigned RO_IDX_W = $clog2(NUM_RO);
    localparam int unsigned CHAL_W   = 2 * RO_IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_COMPARE,
        ST_DONE
    } ro_puf_state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one multiplexed oscillator output and counts its rising edges,
// saturating at the counter maximum.
module ro_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;

    assign rise = sync2 & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            count <= '0;
        end else begin
            sync1 <= ro;
            sync2 <= sync1;
            prev  <= sync2;
            if (clr) begin
                count <= '0;
            end else if (en && rise && (count != CNT_MAX)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_puf_ctrl.sv
// Challenge sequencer: selects two oscillators, settles, counts edges over a
// fixed window and compares the counts into one response bit.
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CHAL_W-1:0]   challenge,
    input  logic                ro_a,
    input  logic                ro_b,
    output logic [RO_IDX_W-1:0] sel_a,
    output logic [RO_IDX_W-1:0] sel_b,
    output logic                ro_en,
    output logic                busy,
    output logic                done,
    output logic                response,
    output logic                tie,
    output logic                err,
    output logic [CNT_W-1:0]    count_a,
    output logic [CNT_W-1:0]    count_b
);

    localparam int unsigned MAX_CYC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

    ro_puf_state_t          state;
    logic [TMR_W-1:0]       tmr;
    logic [RO_IDX_W-1:0]    idx_a;
    logic [RO_IDX_W-1:0]    idx_b;
    logic                   cnt_clr;
    logic                   cnt_en;

    assign idx_a   = challenge[CHAL_W-1:RO_IDX_W];
    assign idx_b   = challenge[RO_IDX_W-1:0];
    assign cnt_clr = (state == ST_IDLE) && start;
    assign cnt_en  = (state == ST_COUNT);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_a),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_b),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            sel_a    <= '0;
            sel_b    <= '0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tmr      <= '0;
                        response <= 1'b0;
                        tie      <= 1'b0;
                        // Same oscillator on both sides would compare a ring against itself.
                        if (idx_a == idx_b) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err   <= 1'b0;
                            sel_a <= idx_a;
                            sel_b <= idx_b;
                            ro_en <= 1'b1;
                            busy  <= 1'b1;
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                        tmr   <= '0;
                        state <= ST_COUNT;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (tmr == TMR_W'(WINDOW_CYCLES - 1)) begin
                        ro_en <= 1'b0;
                        state <= ST_COMPARE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_COMPARE: begin
                    response <= (count_a > count_b);
                    tie      <= (count_a == count_b);
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Scoreboard bench for ro_puf_ctrl: stimulus pushes modelled results, a
// monitor pops and compares them on every done pulse.
module tb_ro_puf_ctrl;

    localparam int unsigned S   = 16;
    localparam int unsigned W   = 1024;
    localparam int unsigned CW  = 16;
    localparam int unsigned S2  = 4;
    localparam int unsigned W2  = 64;
    localparam int unsigned CW2 = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          start2;
    logic [7:0]    challenge;
    logic [7:0]    challenge2;
    logic          ro_a;
    logic          ro_b;

    logic [3:0]    sel_a, sel_b;
    logic          ro_en, busy, done, response, tie, err;
    logic [CW-1:0] count_a, count_b;

    logic [3:0]     sel_a_s, sel_b_s;
    logic           ro_en_s, busy_s, done_s, response_s, tie_s, err_s;
    logic [CW2-1:0] count_a_s, count_b_s;

    typedef struct {
        logic [31:0] done_cyc;
        logic [31:0] err;
        logic [31:0] resp;
        logic [31:0] tie;
        logic [31:0] ca;
        logic [31:0] cb;
        logic [31:0] sa;
        logic [31:0] sb;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned per_a, per_b, ph_a, ph_b;

    ro_puf_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a), .sel_b(sel_b),
        .ro_en(ro_en), .busy(busy), .done(done), .response(response),
        .tie(tie), .err(err), .count_a(count_a), .count_b(count_b)
    );

    ro_puf_ctrl #(.SETTLE_CYCLES(S2), .WINDOW_CYCLES(W2), .CNT_W(CW2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .challenge(challenge2),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a_s), .sel_b(sel_b_s),
        .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(response_s),
        .tie(tie_s), .err(err_s), .count_a(count_a_s), .count_b(count_b_s)
    );

    // Oscillator level during the clk cycle whose posedge index is k.
    function automatic logic wave(input int unsigned k, input int unsigned p, input int unsigned ph);
        return ((k + ph) % p) < (p / 2);
    endfunction

    // Rising edges that reach the counters during the counting window: an edge
    // driven in cycle k is seen by the edge detector two cycles later.
    function automatic int unsigned ref_count(input int unsigned t, input int unsigned s,
                                              input int unsigned w, input int unsigned p,
                                              input int unsigned ph, input int unsigned maxv);
        int unsigned n = 0;
        for (int unsigned k = t + s - 2; k <= t + s + w - 3; k++) begin
            if (wave(k, p, ph) && !wave(k - 1, p, ph)) n++;
        end
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel_a"}, 32'(sel_a), 32'd0);
        check({tag, "_sel_b"}, 32'(sel_b), 32'd0);
        check({tag, "_ro_en"}, 32'(ro_en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_resp"}, 32'(response), 32'd0);
        check({tag, "_tie"}, 32'(tie), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count_a"}, 32'(count_a), 32'd0);
        check({tag, "_count_b"}, 32'(count_b), 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    initial begin
        ro_a = 1'b0;
        ro_b = 1'b0;
        forever begin
            @(negedge clk);
            ro_a = wave(cyc, per_a, ph_a);
            ro_b = wave(cyc, per_b, ph_b);
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cyc", 32'(cyc), e.done_cyc);
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("err", 32'(err), e.err);
                    check("response", 32'(response), e.resp);
                    check("tie", 32'(tie), e.tie);
                    check("count_a", 32'(count_a), e.ca);
                    check("count_b", 32'(count_b), e.cb);
                    if (e.err == 0) begin
                        check("sel_a", 32'(sel_a), e.sa);
                        check("sel_b", 32'(sel_b), e.sb);
                        check("ro_en_at_done", 32'(ro_en), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic [7:0] ch, input int unsigned pa, input int unsigned pb,
                         input int unsigned qa, input int unsigned qb, output int unsigned t);
        exp_t e;
        @(negedge clk);
        per_a = pa; per_b = pb; ph_a = qa; ph_b = qb;
        @(negedge clk);
        challenge = ch;
        start     = 1'b1;
        t         = cyc + 1;
        if (ch[7:4] == ch[3:0]) begin
            e = '{done_cyc: 32'(t), err: 32'd1, resp: 32'd0, tie: 32'd0,
                  ca: 32'd0, cb: 32'd0, sa: 32'd0, sb: 32'd0};
        end else begin
            e.done_cyc = 32'(t + S + W + 1);
            e.err      = 32'd0;
            e.ca       = 32'(ref_count(t, S, W, pa, qa, (1 << CW) - 1));
            e.cb       = 32'(ref_count(t, S, W, pb, qb, (1 << CW) - 1));
            e.resp     = 32'(e.ca > e.cb);
            e.tie      = 32'(e.ca == e.cb);
            e.sa       = 32'(ch[7:4]);
            e.sb       = 32'(ch[3:0]);
        end
        exp_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        challenge = 8'($urandom);
        if (ch[7:4] == ch[3:0]) begin
            check("err_busy", 32'(busy), 32'd0);
            check("err_ro_en", 32'(ro_en), 32'd0);
        end else begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_ro_en", 32'(ro_en), 32'd1);
            check("run_sel_a", 32'(sel_a), 32'(ch[7:4]));
            check("run_sel_b", 32'(sel_b), 32'(ch[3:0]));
        end
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < S + W + 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic sat_run(input int unsigned pb);
        int unsigned t;
        int unsigned n = 0;
        int unsigned ca, cb;
        @(negedge clk);
        per_a = 2; per_b = pb; ph_a = 0; ph_b = 0;
        @(negedge clk);
        challenge2 = 8'h12;
        start2     = 1'b1;
        t          = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        while (!done_s && n < S2 + W2 + 10) begin
            @(negedge clk);
            n++;
        end
        ca = ref_count(t, S2, W2, 2, 0, (1 << CW2) - 1);
        cb = ref_count(t, S2, W2, pb, 0, (1 << CW2) - 1);
        check("sat_done_cyc", 32'(cyc), 32'(t + S2 + W2 + 1));
        check("sat_count_a", 32'(count_a_s), 32'(ca));
        check("sat_count_b", 32'(count_b_s), 32'(cb));
        check("sat_response", 32'(response_s), 32'(ca > cb));
        check("sat_tie", 32'(tie_s), 32'(ca == cb));
        check("sat_err", 32'(err_s), 32'd0);
        check("sat_busy", 32'(busy_s), 32'd0);
        check("sat_ro_en", 32'(ro_en_s), 32'd0);
        check("sat_sel", 32'({sel_a_s, sel_b_s}), 32'h12);
        @(negedge clk);
    endtask

    initial begin
        int unsigned t;
        n_tests    = 0;
        n_fail     = 0;
        per_a      = 4; per_b = 6; ph_a = 0; ph_b = 0;
        start      = 1'b0;
        start2     = 1'b0;
        challenge  = 8'h00;
        challenge2 = 8'h00;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(8'h3A, 4, 6, 0, 0, t);
        wait_done("basic");
        issue(8'h3A, 6, 4, 1, 3, t);
        wait_done("swapped");
        issue(8'h7C, 5, 5, 2, 2, t);
        wait_done("equal");

        // Rejected challenge: single-cycle done, ring never enabled.
        issue(8'h55, 4, 6, 0, 0, t);
        repeat (4) begin
            check("err_idle_ro_en", 32'(ro_en), 32'd0);
            check("err_idle_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        wait_done("err");

        // A start during counting must be dropped entirely.
        issue(8'h91, 3, 7, 0, 1, t);
        repeat (S + 100) @(negedge clk);
        challenge = 8'hC7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_start_sel_a", 32'(sel_a), 32'h9);
        check("busy_start_sel_b", 32'(sel_b), 32'h1);
        check("busy_start_busy", 32'(busy), 32'd1);
        wait_done("busy_start");
        repeat (S + W + 10) @(negedge clk);

        // Reset while counting: outputs clear immediately, no done afterwards.
        issue(8'hE2, 4, 9, 0, 0, t);
        repeat (S + 200) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_reset_vals("post_reset");
        issue(8'h2E, 9, 4, 0, 0, t);
        wait_done("after_reset");

        for (int i = 0; i < 6; i++) begin
            issue(8'($urandom), $urandom_range(9, 2), $urandom_range(9, 2),
                  $urandom_range(8, 0), $urandom_range(8, 0), t);
            wait_done("random");
        end

        sat_run(3);
        sat_run(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Challenge sequencer for the 16-oscillator ring-oscillator PUF. Accepts an 8-bit challenge naming two oscillators, drives the select lines of the two 16:1 oscillator multiplexers, enables the ring array, lets the selected outputs settle, then counts rising edges of both multiplexed oscillator outputs over a fixed window. Compares the two counts to produce one response bit. Sits between the host or response-assembly logic and the oscillator array/mux pair.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 16: clk cycles between mux select/enable and start of counting (min 4).
- `WINDOW_CYCLES`, default 1024: clk cycles of edge counting (min 1).
- `CNT_W`, default 16: edge-counter width.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request evaluation; sampled only in IDLE.
- `challenge` in 8: [7:4] = oscillator A index, [3:0] = oscillator B index.
- `ro_a`, `ro_b` in 1 each: outputs of mux A and mux B; asynchronous to `clk`.
- `sel_a`, `sel_b` out 4 each: select lines to mux A and mux B.
- `ro_en` out 1: ring-oscillator array enable.
- `busy` out 1: high from the cycle after start acceptance until `done`.
- `done` out 1: one-cycle pulse; result valid.
- `response` out 1: 1 if count A > count B.
- `tie` out 1: counts equal.
- `err` out 1: challenge rejected (A index == B index).
- `count_a`, `count_b` out CNT_W each: final window counts, for characterisation.

## Operation

- States: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: `start`=1 latches `challenge`.
  - If [7:4]==[3:0]: go to DONE with `err`=1, `response`=0, `tie`=0, counts 0; `ro_en` stays 0.
  - Otherwise: go to SETTLE, drive `sel_a`/`sel_b` from the latched challenge, assert `ro_en`, clear both counters.
- SETTLE: wait SETTLE_CYCLES cycles; synchronizers run but counters are held at 0.
- COUNT: counters increment on each detected rising edge for exactly WINDOW_CYCLES cycles.
  - Counters saturate at 2^CNT_W−1.
- COMPARE: `ro_en` deasserts; A>B gives `response`=1, `tie`=0; A==B gives `response`=0, `tie`=1; A<B gives 0/0.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `response`/`tie`/`err`/`count_*`/`sel_*` hold their last values until the next accepted `start`.
- Edge detect: 2-flop synchronizer plus a third flop; a rising edge is sync=1 while prev=0. Oscillator frequency after the mux must be < clk/2; faster rings alias, which is not detected.
- `start` while busy is ignored and not queued.
- `challenge` is only sampled on acceptance.
- Reset mid-operation: immediate return to IDLE, `ro_en`=0, counters and results cleared, no `done`.

## Timing

- Reset values: `sel_a`=`sel_b`=0, `ro_en`=0, `busy`=0, `done`=0, `response`=0, `tie`=0, `err`=0, `count_a`=`count_b`=0.
- Start accepted at edge T. `sel_*`, `ro_en` and `busy` are valid after T.
- SETTLE occupies cycles T+1 … T+S. COUNT occupies T+S+1 … T+S+W. COMPARE is at T+S+W+1.
- `done` is high in cycle T+S+W+2, with `busy` low in that cycle.
- A new `start` can be accepted at edge T+S+W+3.
- Error path: `done` at T+1; `busy` never asserts.
- Counts reflect edges whose synchronized detection falls in the COUNT cycles (2–3 clk synchronizer latency, identical for both channels).

## Structure

- Package `ro_puf_pkg`: state enum `ro_puf_state_t`, `NUM_RO`=16, `RO_IDX_W`=4, `CHAL_W`=8.
- Sub-module `ro_edge_counter` (synchronizer, edge detect, clear/enable, saturating counter, CNT_W parameter), instantiated once per channel.
- The FSM and compare logic live in the top block.

## Test plan

- Challenge 8'h3A, `ro_a` period 4 clk, `ro_b` period 6 clk, S=16, W=1024: `sel_a`=3, `sel_b`=10; `done` at T+1042; `count_a`=256±1, `count_b`=170±1, `response`=1, `tie`=0.
- Periods swapped: `response`=0, `tie`=0. Identical 5-clk periods with equal phase: counts equal, `tie`=1, `response`=0.
- Challenge 8'h55: `done` at T+1, `err`=1, `ro_en` never high, `busy` never high.
- `start` pulsed during COUNT with a different challenge: ignored; result and `sel_*` match the original challenge; no extra `done`.
- `rst_n` low during COUNT: all outputs return to reset values asynchronously, no `done`; a following `start` runs normally.
- CNT_W=4, `ro_a` period 2 clk, W=64: `count_a` saturates at 15, `response` correct versus slower `ro_b` at 15 → `tie`=1.
